// File: rtl/rock_pkg.sv
// rock_pkg: shared level type, sequencer states and phase-ordering helper.
package rock_pkg;
  localparam int LEVEL_MAX = 7;
  localparam int LEVEL_W = $clog2(LEVEL_MAX + 1);
  typedef logic [LEVEL_W-1:0] level_t;
  typedef enum logic [2:0] {IDLE, A_DN, F_RAMP, A_UP, FAULT} seq_state_t;
  function automatic seq_state_t next_phase(level_t a, level_t f, level_t ta, level_t tf);
    return ta < a ? A_DN : tf != f ? F_RAMP : ta > a ? A_UP : IDLE;
  endfunction
endpackage

// File: rtl/rock_setpoint_sequencer_dwell_timer.sv
// dwell_timer: dwell countdown between level steps; expired while the count is zero.
module dwell_timer #(
  parameter int DWELL = 1000,
  parameter int DWELL_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);
  logic [DWELL_W-1:0] cnt;
  assign expired = cnt == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= DWELL_W'(DWELL - 1);
    else if (enable && !expired) cnt <= cnt - 1'b1;
endmodule

// File: rtl/rock_setpoint_sequencer.sv
// rock_setpoint_sequencer: safety-ordered A/F setpoint ramping with fault ramp-down.
// Define ROCK_FAULT_LATCH_EN to add fault_clr, required to leave FAULT.
module rock_setpoint_sequencer
  import rock_pkg::*;
#(
  parameter int DWELL = 1000,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [LEVEL_W-1:0] req_A,
  input  logic [LEVEL_W-1:0] req_F,
  output logic               req_ready,
  input  logic               err_in,
`ifdef ROCK_FAULT_LATCH_EN
  input  logic               fault_clr,
`endif
  output logic [LEVEL_W-1:0] A,
  output logic [LEVEL_W-1:0] F,
  output logic               busy,
  output logic               settled,
  output logic               fault
);
  seq_state_t state, state_nxt;
  level_t ta, tf, a_nxt, f_nxt, cur, tgt, moved;
  logic accept, done, expired, hold, step, settled_nxt, clr_ok;
`ifdef ROCK_FAULT_LATCH_EN
  assign clr_ok = fault_clr & ~err_in;
`else
  assign clr_ok = ~err_in;
`endif
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign fault = state == FAULT;
  dwell_timer #(.DWELL(DWELL), .DWELL_W(DWELL_W)) u_dwell (
    .clk(clk), .reset(reset), .load(step), .enable(busy & ~hold), .expired(expired)
  );
  // err_in freezes levels and the dwell count for the edge that enters FAULT
  always_comb begin
    hold = err_in & state != FAULT;
    accept = req_valid & req_ready & ~err_in;
    cur = state == F_RAMP ? F : A;
    tgt = state == F_RAMP ? tf : state == FAULT ? '0 : ta;
    done = cur == tgt;
    moved = tgt > cur ? cur + 1'b1 : cur - 1'b1;
    step = busy & ~hold & expired & ~done;
    a_nxt = step && state != F_RAMP ? moved : A;
    f_nxt = step && state == F_RAMP ? moved : F;
    state_nxt = hold ? FAULT
              : state == IDLE ? (accept ? next_phase(A, F, req_A, req_F) : IDLE)
              : state == FAULT ? (A == '0 && expired && clr_ok ? IDLE : FAULT)
              : done && expired ? next_phase(A, F, ta, tf) : state;
    settled_nxt = state != FAULT && state_nxt == IDLE && (state != IDLE || accept);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      A <= '0;
      F <= '0;
      ta <= '0;
      tf <= '0;
      settled <= 1'b0;
    end else begin
      state <= state_nxt;
      A <= a_nxt;
      F <= f_nxt;
      settled <= settled_nxt;
      if (accept) begin
        ta <= req_A;
        tf <= req_F;
      end
    end
endmodule

// File: tb/tb_rock_setpoint_sequencer.sv
// tb_rock_setpoint_sequencer: directed and random setpoint ramps against a step-schedule model.
module tb_rock_setpoint_sequencer;
  import rock_pkg::*;
  localparam int D = 4;
  typedef struct {int t; bit is_a; int v;} step_t;
  logic clk = 0, reset = 0, req_valid = 0, err_in = 0;
  logic [LEVEL_W-1:0] req_A = '0, req_F = '0, A, F;
  logic req_ready, busy, settled, fault;
`ifdef ROCK_FAULT_LATCH_EN
  logic fault_clr = 0;
`endif
  int n_cmp = 0, n_bad = 0, ma = 0, mf = 0;
  bit held = 0;
  always #5 clk = ~clk;
  rock_setpoint_sequencer #(.DWELL(D), .DWELL_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_A(req_A), .req_F(req_F),
    .req_ready(req_ready), .err_in(err_in),
`ifdef ROCK_FAULT_LATCH_EN
    .fault_clr(fault_clr),
`endif
    .A(A), .F(F), .busy(busy), .settled(settled), .fault(fault)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int ea, input int ef, input int eb, input int es, input int eflt);
    check({tag, " A"}, 32'(A), ea);
    check({tag, " F"}, 32'(F), ef);
    check({tag, " busy"}, 32'(busy), eb);
    check({tag, " settled"}, 32'(settled), es);
    check({tag, " fault"}, 32'(fault), eflt);
    check({tag, " req_ready"}, 32'(req_ready), eb ? 0 : 1);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_all("idle", ma, mf, 0, 0, 0);
    end
  endtask
  // Entered at the negedge after edge e-1 with model levels ma/mf and dwell count c.
  task automatic run_fault(input int c);
    int x, n;
    err_in = 1;
    @(posedge clk);
    @(negedge clk);
    err_in = 0;
    req_valid = 0;
    x = 1 + c + ma * D;
`ifdef ROCK_FAULT_LATCH_EN
    x += 3;
`endif
    for (int j = 0; j < x; j++) begin
      if (j > 0) @(negedge clk);
      n = j < 1 + c ? 0 : (j - 1 - c) / D + 1;
      if (n > ma) n = ma;
      chk_all($sformatf("fault j=%0d", j), ma - n, mf, 1, 0, 1);
`ifdef ROCK_FAULT_LATCH_EN
      if (j == x - 1) fault_clr = 1;
`endif
    end
    @(negedge clk);
`ifdef ROCK_FAULT_LATCH_EN
    fault_clr = 0;
`endif
    chk_all("fault_exit", 0, mf, 0, 0, 0);
    ma = 0;
    held = 0;
  endtask
  // kind: 0 plain, 1 err_in abort, 2 async reset abort; ak<0 picks a random abort edge
  task automatic do_req(input int ta, input int tf, input int kind, input int ak, input bit allow_hold);
    step_t q[$];
    int t, t_end, a, f, ls, c;
    t = 1;
    if (ta < ma) begin
      for (int v = ma - 1; v >= ta; v--) begin q.push_back('{t, 1'b1, v}); t += D; end
      t++;
    end
    if (tf != mf) begin
      for (int i = 1; i <= (tf > mf ? tf - mf : mf - tf); i++) begin
        q.push_back('{t, 1'b0, tf > mf ? mf + i : mf - i});
        t += D;
      end
      t++;
    end
    if (ta > ma) begin
      for (int v = ma + 1; v <= ta; v++) begin q.push_back('{t, 1'b1, v}); t += D; end
      t++;
    end
    t_end = t;
    if (kind != 0 && ak < 0) ak = t_end > 1 ? int'($urandom_range(1, t_end - 1)) : -1;
    if (ak < 1) kind = 0;
    req_valid = 1;
    req_A = LEVEL_W'(ta);
    req_F = LEVEL_W'(tf);
    @(posedge clk);
    @(negedge clk);
    held = kind == 0 && allow_hold && $urandom_range(0, 1) == 1;
    if (held) begin
      req_A = LEVEL_W'($urandom_range(0, LEVEL_MAX));
      req_F = LEVEL_W'($urandom_range(0, LEVEL_MAX));
    end else req_valid = 0;
    for (int k = 0; k < t_end; k++) begin
      if (k > 0) @(negedge clk);
      a = ma;
      f = mf;
      ls = -1;
      foreach (q[i]) if (q[i].t <= k) begin
        if (q[i].is_a) a = q[i].v;
        else f = q[i].v;
        ls = q[i].t;
      end
      chk_all($sformatf("ramp %0d,%0d k=%0d", ta, tf, k), a, f, k < t_end - 1, k == t_end - 1, 0);
      if (kind != 0 && k == ak - 1) begin
        c = ls < 0 ? 0 : ls + D - 1 - k;
        if (c < 0) c = 0;
        ma = a;
        mf = f;
        if (kind == 1) run_fault(c);
        else begin
          #2 reset = 0;
          #1 chk_all("reset_mid", 0, 0, 0, 0, 0);
          @(negedge clk);
          reset = 1;
          ma = 0;
          mf = 0;
          held = 0;
        end
        return;
      end
    end
    ma = ta;
    mf = tf;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_all("reset_hold", 0, 0, 0, 0, 0);
    reset = 1;
    @(negedge clk);
    chk_all("reset_rel", 0, 0, 0, 0, 0);
    do_req(3, 2, 0, -1, 0);
    do_req(5, 1, 0, -1, 0);
    do_req(2, 4, 0, -1, 0);
    do_req(2, 4, 0, -1, 0);
    idle(2);
    do_req(0, 0, 0, -1, 0);
    do_req(3, 2, 1, 20, 0);
    req_valid = 1;
    req_A = LEVEL_W'(5);
    req_F = LEVEL_W'((mf + 3) % 8);
    run_fault(0);
    idle(3);
    do_req(6, 6, 0, -1, 0);
    req_valid = 1;
    req_A = LEVEL_W'(1);
    req_F = LEVEL_W'(3);
    run_fault(0);
    idle(2);
    do_req(7, 7, 2, 6, 0);
    idle(1);
    for (int i = 0; i < 16; i++) begin
      if (held) do_req(int'(req_A), int'(req_F), $urandom_range(0, 3) == 0 ? 1 : 0, -1, 1);
      else begin
        idle(int'($urandom_range(0, 2)));
        do_req(int'($urandom_range(0, LEVEL_MAX)), int'($urandom_range(0, LEVEL_MAX)),
               $urandom_range(0, 3) == 0 ? 1 : 0, -1, 1);
      end
    end
    if (held) do_req(int'(req_A), int'(req_F), 0, -1, 0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rock_setpoint_sequencer.md
Name: rock_setpoint_sequencer

Overview:
- Sits between the amplitude/frequency decision logic and the cradle motor drive.
- Accepts a requested amplitude/frequency setpoint pair, then ramps the motor commands there one level at a time, with a programmable dwell between steps.
- Ordering is safety-first: amplitude decreases, then frequency moves, then amplitude increases.
- On an error input it forces a controlled amplitude ramp-down to zero.

Parameters:
- DWELL, 1000, clock cycles between consecutive level steps (must be ≥1).
- DWELL_W, 16, width of the dwell counter (2^DWELL_W > DWELL).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  new setpoint offered.
- req_A  input  3  target amplitude level 0..7.
- req_F  input  3  target frequency level 0..7.
- req_ready  output  1  high only in IDLE; accept = req_valid & req_ready at a rising edge.
- err_in  input  1  error from the path-finder/math stage (OR of both).
- A  output  3  registered amplitude command.
- F  output  3  registered frequency command.
- busy  output  1  high in any state except IDLE.
- settled  output  1  one-cycle pulse when the setpoint is reached.
- fault  output  1  high while in FAULT.

Behaviour:
- **Reset (reset=0, asynchronous):** state=IDLE, A=0, F=0, targets=0, cnt=0, settled=0, fault=0. req_ready=1 after release.
- **States:** IDLE, A_DN, F_RAMP, A_UP, FAULT. Targets tA/tF are latched on accept.
- **Accept edge t0:**
  - Next state is the first needed phase: A_DN if tA<A, else F_RAMP if tF≠F, else A_UP if tA>A.
  - cnt=0 on entry to that phase.
  - If nothing differs, stay IDLE and settled=1 for the cycle after t0.
- **Step rule inside a phase:**
  - If cnt==0 and the phase quantity ≠ target: step that quantity ±1 toward target and load cnt=DWELL-1.
  - Else if cnt≠0: decrement cnt.
- **Phase exit:** quantity==target and cnt==0 → next needed phase, entered with cnt=0 (one bubble cycle per transition). After the last phase → IDLE with settled=1 for one cycle.
- **Ordering guarantee:** A never exceeds max(start A, tA). F changes only while A ≤ min(start A, tA).
- **Requests outside IDLE** are ignored (req_ready=0); a held req_valid is accepted on return to IDLE.
- **Levels** saturate inside 0..7 by construction; there is no wrap.
- **err_in:** sampled high in any non-FAULT state → FAULT at the next edge, with cnt preserved.
  - In FAULT: A steps down by the same step rule; F is held.
  - Exit to IDLE when A==0, cnt==0 and err_in==0. No settled pulse on this exit.
- **err_in priority:** err_in on the same edge as an accept wins; the request is not latched.
- **Reset mid-ramp** returns everything to reset values immediately.

Optional Feature:
- Macro ROCK_FAULT_LATCH_EN.
- Defined: adds input port fault_clr (1 bit).
  - FAULT exits only when A==0, cnt==0, err_in==0 and fault_clr==1 in the same cycle.
  - fault_clr outside FAULT is ignored.
- Undefined: no fault_clr port; FAULT auto-exits as above.

Decomposition:
- Package rock_pkg:
  - LEVEL_W=3 and typedef level_t.
  - Enum seq_state_t {IDLE, A_DN, F_RAMP, A_UP, FAULT}.
  - Constant LEVEL_MAX=7.
- Sub-module dwell_timer (parameter DWELL/DWELL_W):
  - Inputs: load, enable.
  - Outputs: expired (cnt==0).
  - Shares clk/reset.

Test Plan (DWELL=4):
- **Reset:** hold reset=0 for 3 cycles, release → A=0, F=0, req_ready=1, busy=0, settled=0, fault=0. Assert reset=0 mid-ramp → A=F=0 without waiting for a clock edge.
- **Up ramp:** from (0,0), accept A=3, F=2 at t0 → F=1@t0+1, F=2@t0+5, A=1@t0+10, A=2@t0+14, A=3@t0+18, settled pulse after edge t0+22, then req_ready=1.
- **Mixed ramp:** from (5,1), request (2,4) → A steps 4,3,2 at t0+1/+5/+9, then F 2,3,4 at t0+14/+18/+22. A never >5; F is constant until A==2.
- **Fault:** err_in=1 for one cycle mid-ramp at (3,2) → fault=1 next edge, A ramps 2,1,0 at 4-cycle spacing, F stays 2, back to IDLE with no settled pulse.
  - With ROCK_FAULT_LATCH_EN, the bench stays in FAULT until fault_clr=1.
- **No-op request:** request equal to the current (A,F) → stays IDLE, settled=1 the cycle after t0, A/F unchanged.
- **Busy and err priority:** req_valid held high while busy with another setpoint → not accepted until IDLE, then accepted on the first IDLE edge. err_in and accept on the same edge → FAULT, targets unchanged.
